hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 4, register-specifier width.
REQ-002 clk  in  1  pipeline clock; all state updates on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 id_rs, id_rt  in  REG_AW  source registers of the ID-stage instruction; id_uses_rt  in  1  ID instruction reads rt.
REQ-005 ex_rs, ex_rt  in  REG_AW  source registers of the EX-stage instruction.
REQ-006 ex_rd  in  REG_AW; ex_wr  in  1; ex_is_load  in  1; ex_valid  in  1  EX-stage destination, write enable, load flag, valid.
REQ-007 mem_rd  in  REG_AW; mem_wr  in  1  EX/MEM destination and write enable.
REQ-008 wb_rd  in  REG_AW; wb_wr  in  1  MEM/WB destination and write enable.
REQ-009 ex_opcode  in  4; ex_cond  in  3  EX opcode and branch condition (instr[11:9]).
REQ-010 ex_flags  in  3  ALU flags {N,Z,V} (bit0 V, bit1 Z, bit2 N); ex_set_flags  in  1  EX instruction writes flags.
REQ-011 cache_stall  in  1  memory not ready.
REQ-012 fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
REQ-013 flags_q  out  3  committed flags, fed to ALU flagsIn.
REQ-014 pc_hold, ifid_hold, idex_bubble, flush, take_branch  out  1 each; state  out  2.

Function
REQ-015 FSM states RUN=00, LU_STALL=01, MEM_WAIT=10; encoding is the state output.
REQ-016 fwd_a=10 when mem_wr, mem_rd!=0, mem_rd==ex_rs; else 01 when wb_wr, wb_rd!=0, wb_rd==ex_rs; else 00; fwd_b identical against ex_rt; combinational.
REQ-017 Load-use: ex_valid & ex_is_load & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)).
REQ-018 Branch taken (combinational): ex_valid & (opcode B with cond true on flags_q, or opcode JAL, or opcode JR).
REQ-019 Conditions: 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 N=1|Z=1; 110 V=1; 111 always.
REQ-020 RUN: cache_stall -> MEM_WAIT; else taken -> flush=1, take_branch=1, stay RUN; else load-use -> pc_hold=ifid_hold=idex_bubble=1, go LU_STALL; else outputs 0.
REQ-021 LU_STALL: holds asserted no further cycles; returns to RUN next cycle; load-use stall is exactly 1 cycle.
REQ-022 MEM_WAIT: pc_hold=ifid_hold=1, idex_bubble=0, flush=0, take_branch=0; exit to RUN the cycle after cache_stall falls; EX instruction re-evaluated in RUN.
REQ-023 Priority: cache_stall > branch taken > load-use; taken branch suppresses load-use stall same cycle.
REQ-024 flags_q <= ex_flags when ex_valid & ex_set_flags & state!=MEM_WAIT & !cache_stall; else hold.
REQ-025 Branch evaluated on flags_q before the same-cycle update (no flag bypass).

Reset
REQ-026 rst_n low: state=RUN, flags_q=000 immediately, independent of clk.
REQ-027 During reset all hold/bubble/flush/take_branch outputs 0; fwd_a/fwd_b remain combinational.
REQ-028 Reset release mid-stall resumes in RUN; no stall carried over.

Structure
REQ-029 Opcode constants (B, JAL, JR), condition codes, state and forward-select encodings SHALL live in the shared defines file.
REQ-030 One sub-module, branch_cond (cond, flags -> taken), SHALL hold REQ-019 logic.

Verification
REQ-031 ex_rs=3, mem_wr=1, mem_rd=3, wb_wr=1, wb_rd=3 -> fwd_a=10; mem_rd=0 with ex_rs=0 -> fwd_a=00.
REQ-032 ex_is_load, ex_rd=5, id_rs=5 -> one cycle pc_hold/ifid_hold/idex_bubble=1, state 01, then RUN.
REQ-033 flags_q=010 (Z=1), B with cond 001 -> take_branch=1, flush=1; cond 000 -> take_branch=0.
REQ-034 Taken branch plus load-use same cycle -> flush=1, idex_bubble=0, state stays RUN.
REQ-035 cache_stall high 3 cycles with ex_set_flags, ex_flags=100 -> state 10, flags_q unchanged; updates to 100 after return to RUN.
REQ-036 rst_n low during LU_STALL -> state 00, flags_q 000, all holds 0 without a clock edge.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the hazard controller:
// opcodes, branch conditions, FSM states, forward selects.
package hazard_ctrl_pkg;

    localparam logic [3:0] OP_B   = 4'hC;
    localparam logic [3:0] OP_JAL = 4'hD;
    localparam logic [3:0] OP_JR  = 4'hE;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_MI = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_VS = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_LU_STALL = 2'b01,
        ST_MEM_WAIT = 2'b10
    } hzState_e;

endpackage

// File: rtl/hazard_ctrl_branch_cond.sv
// Branch condition evaluator.
// flags = {N, Z, V}.
module branch_cond
    import hazard_ctrl_pkg::*;
(
    input  logic [2:0] cond,
    input  logic [2:0] flags,
    output logic       taken
);

    logic flagN;
    logic flagZ;
    logic flagV;

    assign flagN = flags[2];
    assign flagZ = flags[1];
    assign flagV = flags[0];

    // Decode the condition code against the committed flags.
    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_NE: taken = !flagZ;
            CC_EQ: taken = flagZ;
            CC_GT: taken = !flagZ && !flagN;
            CC_MI: taken = flagN;
            CC_GE: taken = flagZ || (!flagZ && !flagN);
            CC_LE: taken = flagN || flagZ;
            CC_VS: taken = flagV;
            CC_AL: taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding,
// load-use stall, branch flush and memory-wait hold.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_wr,
    input  logic              ex_is_load,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_wr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_wr,
    input  logic [3:0]        ex_opcode,
    input  logic [2:0]        ex_cond,
    input  logic [2:0]        ex_flags,
    input  logic              ex_set_flags,
    input  logic              cache_stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [2:0]        flags_q,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_bubble,
    output logic              flush,
    output logic              take_branch,
    output logic [1:0]        state
);

    hzState_e curState;
    hzState_e nxtState;
    logic     condTrue;
    logic     brTaken;
    logic     loadUse;
    logic     memHitA;
    logic     memHitB;
    logic     wbHitA;
    logic     wbHitB;
    logic     unusedExWr;

    // Write enable of the EX instruction is not needed:
    // the load flag alone marks a load-use producer.
    assign unusedExWr = ex_wr;

    branch_cond uCond (
        .cond  (ex_cond),
        .flags (flags_q),
        .taken (condTrue)
    );

    assign memHitA = mem_wr && (mem_rd != '0) && (mem_rd == ex_rs);
    assign memHitB = mem_wr && (mem_rd != '0) && (mem_rd == ex_rt);
    assign wbHitA  = wb_wr && (wb_rd != '0) && (wb_rd == ex_rs);
    assign wbHitB  = wb_wr && (wb_rd != '0) && (wb_rd == ex_rt);

    // Operand forwarding: youngest producer (EX/MEM) wins.
    always_comb begin
        fwd_a = FWD_RF;
        fwd_b = FWD_RF;
        if (memHitA)     fwd_a = FWD_MEM;
        else if (wbHitA) fwd_a = FWD_WB;
        if (memHitB)     fwd_b = FWD_MEM;
        else if (wbHitB) fwd_b = FWD_WB;
    end

    assign brTaken = ex_valid && (
        ((ex_opcode == OP_B) && condTrue) ||
        (ex_opcode == OP_JAL) ||
        (ex_opcode == OP_JR));

    assign loadUse = ex_valid && ex_is_load && (ex_rd != '0) &&
        ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) curState <= ST_RUN;
        else        curState <= nxtState;
    end

    // Next-state: memory wait beats branch beats load-use.
    always_comb begin
        nxtState = ST_RUN;
        case (curState)
            ST_RUN: begin
                if (cache_stall)  nxtState = ST_MEM_WAIT;
                else if (brTaken) nxtState = ST_RUN;
                else if (loadUse) nxtState = ST_LU_STALL;
                else              nxtState = ST_RUN;
            end
            ST_LU_STALL: nxtState = ST_RUN;
            ST_MEM_WAIT: begin
                if (cache_stall) nxtState = ST_MEM_WAIT;
                else             nxtState = ST_RUN;
            end
            default: nxtState = ST_RUN;
        endcase
    end

    // Pipeline control outputs; all quiet while in reset.
    always_comb begin
        pc_hold     = 1'b0;
        ifid_hold   = 1'b0;
        idex_bubble = 1'b0;
        flush       = 1'b0;
        take_branch = 1'b0;
        if (rst_n) begin
            case (curState)
                ST_RUN: begin
                    if (cache_stall) begin
                        pc_hold   = 1'b1;
                        ifid_hold = 1'b1;
                    end else if (brTaken) begin
                        flush       = 1'b1;
                        take_branch = 1'b1;
                    end else if (loadUse) begin
                        pc_hold     = 1'b1;
                        ifid_hold   = 1'b1;
                        idex_bubble = 1'b1;
                    end
                end
                ST_MEM_WAIT: begin
                    pc_hold   = 1'b1;
                    ifid_hold = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Committed flags; frozen while memory is not ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= 3'b000;
        end else if (ex_valid && ex_set_flags &&
                     (curState != ST_MEM_WAIT) && !cache_stall) begin
            flags_q <= ex_flags;
        end
    end

    assign state = curState;

endmodule
